// File: rtl/rr_grant_gen_pkg.sv
// Shared definitions for the round-robin grant generator.
//   N_REQ   : requester count, fixed to the downstream 8-to-3 encoder width
//   IDX_W   : requester index width
//   state_t : arbiter FSM states
//   onehot  : index -> one-hot grant vector, bit 0 = MSB (encoder index 0)
package rr_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic logic [0:N_REQ-1] onehot(input logic [IDX_W-1:0] idx);
    logic [0:N_REQ-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_grant_gen_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   en      : arbiter enable
//   req     : request lines, req[i] -> encoder index i
//   done    : holder releases its grant
//   gnt     : registered one-hot grant (zero = no grant)
//   busy    : grant held
//   timeout : forced-release pulse
// master drives the requests, slave (the arbiter) drives the grant side.
interface rr_grant_gen_if;
  import rr_arb_pkg::*;

  logic             en;
  logic [0:N_REQ-1] req;
  logic             done;
  logic [0:N_REQ-1] gnt;
  logic             busy;
  logic             timeout;

  modport master (output en, req, done, input gnt, busy, timeout);
  modport slave  (input en, req, done, output gnt, busy, timeout);

endinterface

// File: rtl/rr_grant_gen_pick.sv
// Combinational rotated-priority selector.
//   req      : request lines
//   ptr      : index with highest priority this cycle
//   pick_idx : first requesting index scanning ptr, ptr+1, ... (mod 8)
//   pick_vld : at least one request present
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [0:N_REQ-1] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // IDX_W-bit add wraps naturally at N_REQ
      if (!pick_vld && req[ptr + IDX_W'(k)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/rr_grant_gen.sv
// Round-robin arbiter feeding the 8-to-3 encoder with a registered,
// strictly one-hot (or zero) grant vector.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : request/grant bundle (slave side)
// A release always passes through IDLE, so gnt is zero for at least one
// cycle between grants. MAX_HOLD bounds how long a grant can be held.
module rr_grant_gen
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
)(
  input logic          clk,
  input logic          rst_n,
  rr_grant_gen_if.slave bus
);

  state_t           state_q, state_d;
  logic [0:N_REQ-1] gnt_q,   gnt_d;
  logic [IDX_W-1:0] gidx_q,  gidx_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             to_q,    to_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  rr_pick u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && pick_vld) begin
          state_d = BUSY;
          gnt_d   = onehot(pick_idx);
          gidx_d  = pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end
      BUSY: begin
        if (!bus.en) begin
          // abort: pointer left alone so the same requester wins again
          state_d = IDLE;
          gnt_d   = '0;
        end else if (bus.done || !bus.req[gidx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = gidx_q + IDX_W'(1);
        end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = gidx_q + IDX_W'(1);
          to_d    = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_grant_gen.sv
module tb_rr_grant_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_grant_gen_if bus ();

  rr_grant_gen #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         chk;
    logic [0:7] gnt;
    bit         busy;
    bit         to;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 0;
  bit   rand_on = 0;

  // one entry per clock edge: expected outputs after that edge
  task automatic cyc(input bit chk, input logic [0:7] g, input bit to, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.chk = chk; e.gnt = g; e.busy = (g != 8'b0); e.to = to; e.name = nm;
    sb.push_back(e);
  endtask

  // monitor: scoreboard pops, invariants, fairness
  logic [0:7] p_req, p_gnt;
  bit         p_en, p_to, have_prev;
  int         wait_cnt [8];

  initial begin
    exp_t e;
    bit   adv;
    have_prev = 0;
    p_to = 0;
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          checks++;
          if (bus.gnt !== e.gnt || bus.busy !== e.busy || bus.timeout !== e.to) begin
            errors++;
            $display("FAIL %s: got gnt=%b busy=%b timeout=%b, want gnt=%b busy=%b timeout=%b",
                     e.name, bus.gnt, bus.busy, bus.timeout, e.gnt, e.busy, e.to);
          end
        end
      end
      if (mon_on) begin
        checks++;
        if (!$onehot0(bus.gnt)) begin
          errors++;
          $display("FAIL onehot: got gnt=%b, want one-hot or zero", bus.gnt);
        end
        checks++;
        if (bus.busy !== (|bus.gnt)) begin
          errors++;
          $display("FAIL busy_eq: got busy=%b, want %b", bus.busy, |bus.gnt);
        end
        checks++;
        if (bus.timeout === 1'b1 && p_to) begin
          errors++;
          $display("FAIL timeout_pulse: got timeout high two cycles, want single pulse");
        end
        if (rand_on && have_prev) begin
          adv = (p_gnt != 8'b0) && (bus.gnt == 8'b0) && p_en;
          for (int i = 0; i < 8; i++) begin
            if (!p_req[i] || bus.gnt[i] || p_gnt[i]) begin
              wait_cnt[i] = 0;
            end else if (adv) begin
              wait_cnt[i]++;
              checks++;
              if (wait_cnt[i] > 8) begin
                errors++;
                $display("FAIL fairness: requester %0d waited %0d releases, want <= 8", i, wait_cnt[i]);
              end
            end
          end
        end else begin
          foreach (wait_cnt[i]) wait_cnt[i] = 0;
        end
        p_req = bus.req;
        p_gnt = bus.gnt;
        p_en  = bus.en;
        p_to  = bus.timeout;
        have_prev = 1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; bus.en = 1'b0; bus.req = 8'b0; bus.done = 1'b0;
    cyc(1, 8'b0, 0, "reset0");
    mon_on = 1;
    cyc(1, 8'b0, 0, "reset1");
    rst_n = 1'b1;

    // 1: single request, 1-cycle latency
    bus.en = 1'b1; bus.req = 8'b00010000;
    cyc(1, 8'b00010000, 0, "t1_grant");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t1_release");
    bus.done = 1'b0; bus.req = 8'b0;
    cyc(1, 8'b0, 0, "t1_idle");

    // 2: ptr back to 0, alternate between index 0 and 7
    rst_n = 1'b0;
    cyc(1, 8'b0, 0, "t2_reset");
    rst_n = 1'b1; bus.req = 8'b10000001;
    cyc(1, 8'b10000000, 0, "t2_g0");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t2_gap0");
    bus.done = 1'b0;
    cyc(1, 8'b00000001, 0, "t2_g7");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t2_gap1");
    bus.done = 1'b0;
    cyc(1, 8'b10000000, 0, "t2_g0b");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t2_gap2");
    bus.done = 1'b0; bus.req = 8'b0;
    cyc(1, 8'b0, 0, "t2_idle");

    // 3: hold timeout on index 2 (ptr=1), index 5 waiting
    bus.req = 8'b00100000;
    cyc(1, 8'b00100000, 0, "t3_grant");
    bus.req = 8'b00100100;
    for (int n = 0; n < 15; n++) cyc(1, 8'b00100000, 0, "t3_hold");
    cyc(1, 8'b0, 1, "t3_timeout");
    cyc(1, 8'b00000100, 0, "t3_next_higher");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t3_release");
    // done on the limit cycle: normal release, no timeout (ptr=6)
    bus.done = 1'b0; bus.req = 8'b00000010;
    cyc(1, 8'b00000010, 0, "t3b_grant");
    for (int n = 0; n < 15; n++) cyc(1, 8'b00000010, 0, "t3b_hold");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t3b_done_at_limit");
    bus.done = 1'b0; bus.req = 8'b0;
    cyc(1, 8'b0, 0, "t3b_idle");

    // 4: abort by en, ptr=7 kept -> index 4 again rather than 6
    bus.req = 8'b00001010;
    cyc(1, 8'b00001000, 0, "t4_grant");
    cyc(1, 8'b00001000, 0, "t4_hold");
    bus.en = 1'b0;
    cyc(1, 8'b0, 0, "t4_abort");
    cyc(1, 8'b0, 0, "t4_disabled");
    bus.en = 1'b1;
    cyc(1, 8'b00001000, 0, "t4_regrant");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t4_release");
    bus.done = 1'b0; bus.req = 8'b0;
    cyc(1, 8'b0, 0, "t4_idle");

    // 5: reset mid-grant (ptr=5)
    bus.req = 8'b00100000;
    cyc(1, 8'b00100000, 0, "t5_grant");
    rst_n = 1'b0;
    cyc(1, 8'b0, 0, "t5_reset");
    rst_n = 1'b1; bus.req = 8'b11111111;
    cyc(1, 8'b10000000, 0, "t5_allones");
    bus.done = 1'b1;
    cyc(1, 8'b0, 0, "t5_release");
    bus.done = 1'b0; bus.req = 8'b0;
    cyc(1, 8'b0, 0, "t5_idle");

    // 6: random traffic, invariants and fairness checked by the monitor
    rand_on = 1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 8'($urandom);
      bus.en   = ($urandom_range(0, 9) != 0);
      bus.done = ($urandom_range(0, 4) == 0);
      cyc(0, 8'b0, 0, "rand");
    end
    rand_on = 0;

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
